// File: rtl/bert_pkg.sv
// Shared definitions for the BERT PRBS generator: FSM states, error-rate
// terminal counts and polynomial-length helpers.
package bert_pkg;

  localparam int MAX_POLY_LEN = 24;

  typedef enum logic [1:0] {
    GEN_IDLE = 2'd0,
    GEN_LOAD = 2'd1,
    GEN_RUN  = 2'd2
  } gen_state_t;

  // Bits between injected errors minus one; select 7 repeats the 1e-7 rate.
  localparam logic [23:0] RATE_TC [0:7] = '{
    24'd0, 24'd99, 24'd999, 24'd9999,
    24'd99999, 24'd999999, 24'd9999999, 24'd9999999
  };

  function automatic logic [4:0] clamp_len(input logic [4:0] len);
    if (len < 5'd2) begin
      return 5'd2;
    end else if (len > 5'(MAX_POLY_LEN)) begin
      return 5'(MAX_POLY_LEN);
    end else begin
      return len;
    end
  endfunction

  function automatic logic [MAX_POLY_LEN-1:0] len_mask(input logic [4:0] len);
    return {MAX_POLY_LEN{1'b1}} >> (5'(MAX_POLY_LEN) - len);
  endfunction

endpackage

// File: rtl/bert_pn_generator_lfsr_core.sv
// Fibonacci LFSR register for the PRBS generator: seed load, shift with
// masked feedback, and all-zero lock-up recovery.
module bert_lfsr_core #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] poly,
  input  logic [W-1:0] mask,
  input  logic [4:0]   len,
  output logic         out_bit,
  output logic         all_ones,
  output logic         all_zero
);

  logic [W-1:0] state_r;
  logic [W-1:0] shifted_s;
  logic         fb_s;

  assign fb_s      = ^(state_r & poly & mask);
  assign shifted_s = ((state_r << 1) | {{(W-1){1'b0}}, fb_s}) & mask;
  assign out_bit   = state_r[len - 5'd1];
  assign all_ones  = (state_r == mask);
  assign all_zero  = (state_r == {W{1'b0}});

  // State register; a zero state is reseeded instead of shifted so it cannot stick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= {W{1'b1}};
    end else if (load) begin
      state_r <= mask;
    end else if (step) begin
      state_r <= all_zero ? mask : shifted_s;
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: rtl/bert_pn_generator.sv
// BERT transmit PRBS source with rate-based and single-shot error injection.
// Optional macro BERT_GEN_ERR_COUNT_EN builds the inserted-error counter.
module bert_pn_generator #(
  parameter int MAX_POLY_LEN = 24,
  parameter int RATE_CNT_W   = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    run,
  input  logic [MAX_POLY_LEN-1:0] poly,
  input  logic [4:0]              poly_length,
  input  logic                    poly_mode,
  input  logic [2:0]              error_rate_sel,
  input  logic                    single_error,
  output logic                    data,
  output logic                    data_valid,
  output logic                    seq_start,
  output logic                    error_flag,
  output logic                    lockup,
  output logic [31:0]             errors_inserted
);
  import bert_pkg::*;

  gen_state_t              state_r, next_s;
  logic [4:0]              len_s, len_prev_r;
  logic [MAX_POLY_LEN-1:0] mask_s, poly_prev_r;
  logic [2:0]              sel_prev_r;
  logic [RATE_CNT_W-1:0]   rate_cnt_r, rate_tc_s;
  logic cfg_change_s, sel_change_s, load_s, emit_s;
  logic out_bit_s, all_ones_s, all_zero_s;
  logic pending_r, rate_hit_s, single_hit_s, inject_s;
  logic data_r, valid_r, seq_r, err_r, lock_r;

  assign len_s        = clamp_len(poly_length);
  assign mask_s       = len_mask(len_s);
  assign cfg_change_s = (len_s != len_prev_r) || (poly != poly_prev_r);
  assign sel_change_s = (error_rate_sel != sel_prev_r);
  assign rate_tc_s    = RATE_CNT_W'(RATE_TC[error_rate_sel]);

  bert_lfsr_core #(.W(MAX_POLY_LEN)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .step     (emit_s),
    .poly     (poly),
    .mask     (mask_s),
    .len      (len_s),
    .out_bit  (out_bit_s),
    .all_ones (all_ones_s),
    .all_zero (all_zero_s)
  );

  // Next state; a bit is only emitted in RUN with an unchanged polynomial.
  always_comb begin
    next_s = state_r;
    load_s = 1'b0;
    emit_s = 1'b0;
    case (state_r)
      GEN_IDLE: begin
        if (run) next_s = GEN_LOAD;
        else     next_s = GEN_IDLE;
      end
      GEN_LOAD: begin
        load_s = 1'b1;
        next_s = GEN_RUN;
      end
      GEN_RUN: begin
        if (!run)              next_s = GEN_IDLE;
        else if (cfg_change_s) next_s = GEN_LOAD;
        else begin
          next_s = GEN_RUN;
          emit_s = enable;
        end
      end
      default: next_s = GEN_IDLE;
    endcase
  end

  // A rate hit and a single-shot request on the same bit collapse into one inversion.
  always_comb begin
    rate_hit_s   = emit_s && !sel_change_s && (error_rate_sel != 3'd0) &&
                   (rate_cnt_r == rate_tc_s);
    single_hit_s = emit_s && (pending_r || single_error);
    inject_s     = rate_hit_s || single_hit_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= GEN_IDLE;
      len_prev_r  <= 5'd2;
      poly_prev_r <= {MAX_POLY_LEN{1'b0}};
      sel_prev_r  <= 3'd0;
    end else begin
      state_r     <= next_s;
      len_prev_r  <= len_s;
      poly_prev_r <= poly;
      sel_prev_r  <= error_rate_sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rate_cnt_r <= {RATE_CNT_W{1'b0}};
      pending_r  <= 1'b0;
    end else begin
      if (load_s || sel_change_s)                 rate_cnt_r <= {RATE_CNT_W{1'b0}};
      else if (rate_hit_s)                        rate_cnt_r <= {RATE_CNT_W{1'b0}};
      else if (emit_s && error_rate_sel != 3'd0)  rate_cnt_r <= rate_cnt_r + RATE_CNT_W'(1);
      else                                        rate_cnt_r <= rate_cnt_r;
      if (emit_s)            pending_r <= 1'b0;
      else if (single_error) pending_r <= 1'b1;
      else                   pending_r <= pending_r;
    end
  end

  // Output register stage: everything describes the bit emitted on the previous clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r  <= 1'b0;
      valid_r <= 1'b0;
      seq_r   <= 1'b0;
      err_r   <= 1'b0;
      lock_r  <= 1'b0;
    end else begin
      data_r  <= emit_s ? (out_bit_s ^ poly_mode ^ inject_s) : 1'b0;
      valid_r <= emit_s;
      seq_r   <= emit_s && all_ones_s;
      err_r   <= inject_s;
      lock_r  <= emit_s && all_zero_s;
    end
  end

  assign data       = data_r;
  assign data_valid = valid_r;
  assign seq_start  = seq_r;
  assign error_flag = err_r;
  assign lockup     = lock_r;

`ifdef BERT_GEN_ERR_COUNT_EN
  logic [31:0] errors_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errors_r <= 32'd0;
    end else if (state_r == GEN_IDLE && next_s == GEN_LOAD) begin
      errors_r <= 32'd0;
    end else if (inject_s && errors_r != 32'hFFFF_FFFF) begin
      errors_r <= errors_r + 32'd1;
    end else begin
      errors_r <= errors_r;
    end
  end

  assign errors_inserted = errors_r;
`else
  assign errors_inserted = 32'd0;
`endif

endmodule

// File: tb/tb_bert_pn_generator.sv
// Self-checking bench for bert_pn_generator: a bit-window recurrence model
// predicts every output each clock; directed steps cover the named corner cases.
module tb_bert_pn_generator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable, run, poly_mode, single_error;
  logic [23:0] poly;
  logic [4:0]  poly_length;
  logic [2:0]  error_rate_sel;
  logic        data, data_valid, seq_start, error_flag, lockup;
  logic [31:0] errors_inserted;

  always #5 clk = ~clk;

  bert_pn_generator dut (
    .clk(clk), .reset(reset), .enable(enable), .run(run), .poly(poly),
    .poly_length(poly_length), .poly_mode(poly_mode),
    .error_rate_sel(error_rate_sel), .single_error(single_error),
    .data(data), .data_valid(data_valid), .seq_start(seq_start),
    .error_flag(error_flag), .lockup(lockup), .errors_inserted(errors_inserted)
  );

  int n_cmp = 0;
  int n_fail = 0;

  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2;
  int          m_phase, m_l_prev;
  logic [23:0] m_poly_prev;
  logic [2:0]  m_sel_prev;
  bit          m_pend;
  int unsigned m_cnt;
  logic [31:0] m_errs;
  bit          m_win[$];
  bit          e_data, e_valid, e_seq, e_err, e_lock;

  int nv, ones, nseq, last_seq, nerr, last_err, nlock, budget;
  bit got;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_l(input logic [4:0] pl);
    int v;
    v = int'(pl);
    if (v < 2) return 2;
    if (v > 24) return 24;
    return v;
  endfunction

  function automatic int unsigned rate_tc(input logic [2:0] sel);
    int unsigned p;
    int e;
    p = 1;
    e = (sel == 3'd7) ? 7 : int'(sel) + 1;
    repeat (e) p = p * 10;
    return p - 1;
  endfunction

  function automatic logic [31:0] exp_count(input logic [31:0] c);
`ifdef BERT_GEN_ERR_COUNT_EN
    return c;
`else
    return 32'd0 & c;
`endif
  endfunction

  task automatic model_init();
    m_phase = P_IDLE; m_l_prev = 2; m_poly_prev = 24'd0; m_sel_prev = 3'd0;
    m_pend = 1'b0; m_cnt = 0; m_errs = 32'd0; m_win.delete();
  endtask

  // One clock: predict from current inputs, clock the DUT, compare #1 later.
  task automatic step();
    int l, n;
    bit chg, sel_chg, was_load, emit, rerr, shit, allz, allo, b, nb;
    l = clamp_l(poly_length);
    chg = (l != m_l_prev) || (poly != m_poly_prev);
    sel_chg = (error_rate_sel != m_sel_prev);
    was_load = (m_phase == P_LOAD);
    emit = 1'b0;
    {e_data, e_valid, e_seq, e_err, e_lock} = 5'b0;
    case (m_phase)
      P_IDLE: if (run) begin m_phase = P_LOAD; m_errs = 32'd0; end
      P_LOAD: begin
        m_win.delete();
        for (int i = 0; i < l; i++) m_win.push_back(1'b1);
        m_phase = P_RUN;
      end
      default: begin
        if (!run) m_phase = P_IDLE;
        else if (chg) m_phase = P_LOAD;
        else emit = enable;
      end
    endcase
    rerr = 1'b0;
    if (was_load || sel_chg) m_cnt = 0;
    else if (emit && error_rate_sel != 3'd0) begin
      if (m_cnt == rate_tc(error_rate_sel)) begin m_cnt = 0; rerr = 1'b1; end
      else m_cnt++;
    end
    shit = 1'b0;
    if (emit) begin shit = m_pend || single_error; m_pend = 1'b0; end
    else if (single_error) m_pend = 1'b1;
    if (emit) begin
      n = m_win.size(); allz = 1'b1; allo = 1'b1;
      foreach (m_win[i]) begin if (m_win[i]) allz = 1'b0; else allo = 1'b0; end
      if (allz) begin
        b = 1'b0; e_lock = 1'b1;
        foreach (m_win[i]) m_win[i] = 1'b1;
      end else begin
        b = m_win[0]; nb = 1'b0;
        for (int k = 0; k < n; k++) if (poly[k]) nb ^= m_win[n-1-k];
        void'(m_win.pop_front());
        m_win.push_back(nb);
      end
      e_valid = 1'b1; e_seq = allo; e_err = rerr | shit;
      e_data = b ^ poly_mode ^ e_err;
      if (e_err && m_errs != 32'hFFFF_FFFF) m_errs++;
    end
    m_l_prev = l; m_poly_prev = poly; m_sel_prev = error_rate_sel;
    @(posedge clk);
    #1;
    chk("data", data, e_data);
    chk("data_valid", data_valid, e_valid);
    chk("seq_start", seq_start, e_seq);
    chk("error_flag", error_flag, e_err);
    chk("lockup", lockup, e_lock);
    chk("errors_inserted", errors_inserted, exp_count(m_errs));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"}, data, 1'b0);
    chk({tag, "_valid"}, data_valid, 1'b0);
    chk({tag, "_seq"}, seq_start, 1'b0);
    chk({tag, "_err"}, error_flag, 1'b0);
    chk({tag, "_lock"}, lockup, 1'b0);
    chk({tag, "_count"}, errors_inserted, 32'd0);
  endtask

  task automatic restart();
    run = 1'b0; enable = 1'b0;
    step(); step();
  endtask

  initial begin
    enable = 1'b0; run = 1'b0; poly_mode = 1'b0; single_error = 1'b0;
    poly = 24'h000110; poly_length = 5'd9; error_rate_sel = 3'd0;
    #2 reset = 1'b1;
    #1 check_all_zero("reset");
    @(negedge clk) reset = 1'b0;
    model_init();

    // PN9, continuous enable
    run = 1'b1; enable = 1'b1;
    nv = 0; ones = 0; nseq = 0; last_seq = -1; budget = 0;
    while (nv < 2044 && budget < 2100) begin
      step(); budget++;
      if (data_valid) begin
        if (nv < 9 && data) ones++;
        if (seq_start) begin
          if (last_seq >= 0) chk("pn9_period", nv - last_seq, 511);
          last_seq = nv; nseq++;
        end
        nv++;
      end
    end
    chk("pn9_bits", nv, 2044);
    chk("pn9_first_ones", ones, 9);
    chk("pn9_seq_count", nseq, 4);

    // Rate 1e-2 over 10000 bits
    restart();
    error_rate_sel = 3'd1; run = 1'b1; enable = 1'b1;
    nv = 0; nerr = 0; last_err = -1; budget = 0;
    while (nv < 10000 && budget < 10100) begin
      step(); budget++;
      if (data_valid) begin
        if (error_flag) begin
          if (last_err >= 0) begin
            if (nv - last_err != 100) chk("rate_spacing", nv - last_err, 100);
          end else chk("rate_first", nv, 99);
          last_err = nv; nerr++;
        end
        nv++;
      end
    end
    chk("rate_errors", nerr, 100);
    chk("rate_counter", errors_inserted, exp_count(32'd100));

    // single_error on a terminal-count bit: one inversion, counted once
    budget = 0;
    while (m_cnt != rate_tc(3'd1) && budget < 200) begin step(); budget++; end
    chk("tc_reached", m_cnt, rate_tc(3'd1));
    single_error = 1'b1; step(); single_error = 1'b0;
    chk("coinc_flag", error_flag, 1'b1);
    chk("coinc_count", errors_inserted, exp_count(32'd101));
    step();
    chk("coinc_pending_cleared", error_flag, 1'b0);

    // single_error in IDLE applies to first RUN bit
    restart();
    error_rate_sel = 3'd0;
    single_error = 1'b1; step(); single_error = 1'b0; step();
    run = 1'b1; enable = 1'b1; got = 1'b0; budget = 0;
    while (!got && budget < 10) begin step(); budget++; got = data_valid; end
    chk("idle_single_valid", got, 1'b1);
    chk("idle_single_flag", error_flag, 1'b1);
    step();
    chk("idle_single_once", error_flag, 1'b0);

    // poly = 0 mid-run: reload, then lock-up every L+1 bits
    poly_mode = 1'b1; poly = 24'd0;
    nv = 0; nlock = 0; budget = 0;
    while (nv < 50 && budget < 60) begin
      step(); budget++;
      if (data_valid) begin
        if (lockup) begin nlock++; chk("lock_bit", data, 1'b1); end
        nv++;
      end
    end
    chk("lock_count", nlock, 5);

    // length change mid-run: next bit starts a new period
    poly = 24'h000110; poly_mode = 1'b0;
    repeat (20) step();
    poly_length = 5'd31; poly = 24'hE10000;
    got = 1'b0; budget = 0;
    while (!got && budget < 6) begin step(); budget++; got = data_valid; end
    chk("len_change_valid", got, 1'b1);
    chk("len_change_seq", seq_start, 1'b1);

    // PN15 inverted, enable every 3rd clk
    restart();
    poly = 24'h006000; poly_length = 5'd15; poly_mode = 1'b1; run = 1'b1;
    nv = 0; ones = 0;
    for (int c = 0; c < 2100; c++) begin
      enable = (c % 3 == 0);
      step();
      if (data_valid) begin
        if (nv < 15 && data) ones++;
        nv++;
      end
    end
    chk("pn15_first_zeros", ones, 0);

    // Randomized configuration and traffic
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) begin
        poly_length = 5'($urandom_range(0, 31));
        poly = 24'($urandom);
        poly_mode = 1'($urandom_range(0, 1));
      end
      if (c % 1000 == 0) error_rate_sel = 3'($urandom_range(0, 2));
      enable = ($urandom_range(0, 3) != 0);
      single_error = ($urandom_range(0, 49) == 0);
      run = ($urandom_range(0, 299) != 0);
      step();
    end
    single_error = 1'b0;

    // Reset mid-run
    run = 1'b1; enable = 1'b1;
    repeat (5) step();
    #1 reset = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk) reset = 1'b0;
    model_init();
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
